ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

PS/2 host-to-device transmitter. It sends one command byte (for example 0xF4 "enable data reporting" or 0xFF "reset") from the FPGA to the mouse, following the PS/2 host-request protocol. It is the counterpart of the mouse receive path: it shares the PS2Clk/PS2Data pins through open-drain enables that the top level merges onto the IOBUFs. It runs in the 65 MHz pixel clock domain.

## Interface
Parameters:
- CLK_HOLD_CYCLES, 6500: cycles PS2Clk is held low for the request-to-send (100 us at 65 MHz).
- TIMEOUT_CYCLES, 1300000: maximum cycles from clock release to ack (20 ms); exceeding it aborts the transfer.
- FILTER_LEN, 8: consecutive low samples needed to qualify a falling edge (used only with the filter macro).

Ports:
- clk  in  1  system clock, 65 MHz.
- rst_n  in  1  reset. **Asynchronous, active-low.**
- tx_data  in  8  command byte, latched on accept.
- tx_valid  in  1  request to send tx_data.
- tx_ready  out  1  high in IDLE only.
- tx_done  out  1  one-cycle pulse: byte acked by the device and bus idle.
- tx_err  out  1  one-cycle pulse: NACK or timeout.
- ps2_clk_in  in  1  raw PS2Clk pin level (asynchronous).
- ps2_data_in  in  1  raw PS2Data pin level (asynchronous).
- ps2_clk_oe  out  1  1 = drive PS2Clk low, 0 = release.
- ps2_data_oe  out  1  1 = drive PS2Data low, 0 = release.

## Operation
- ps2_clk_in and ps2_data_in each pass through a 2-flop synchronizer.
- A falling edge of the device clock is detected when the synchronized clock was high in the previous cycle and is low in the current cycle.
- States:
  - IDLE: tx_ready=1, both enables 0. The block accepts a byte when tx_valid && tx_ready, latches shift = tx_data and parity = ~^tx_data (odd parity), then goes to INHIBIT.
  - INHIBIT: ps2_clk_oe=1 for CLK_HOLD_CYCLES cycles, then go to START.
  - START: ps2_data_oe=1 (start bit 0) with ps2_clk_oe still 1 for 1 cycle. Next cycle, clear ps2_clk_oe, clear the timeout counter, set bit_cnt=0, go to SEND.
  - SEND: on each device falling edge k (k = 0..9), set ps2_data_oe = ~bit_k. Bits 0–7 are LSB first, bit 8 is parity, bit 9 is the stop bit (1, released). After k=9, go to ACK.
  - ACK: on the next falling edge, sample the synchronized data line.
    - 0 → go to WAIT_IDLE.
    - 1 → pulse tx_err, go to IDLE.
  - WAIT_IDLE: wait until both synchronized lines are 1, pulse tx_done, go to IDLE.
- Timeout: the counter runs in SEND, ACK and WAIT_IDLE. When it reaches TIMEOUT_CYCLES: pulse tx_err, clear both enables, go to IDLE.
- tx_valid is ignored outside IDLE. tx_done and tx_err never assert together.
- Reset:
  - All outputs 0, except tx_ready=1.
  - State IDLE; counters, shift register and synchronizers cleared (synchronizers to 1).
  - Reset during any state releases both lines immediately, because reset is asynchronous.

## Timing
- Accept at cycle T → tx_ready=0 and ps2_clk_oe=1 at T+1.
- ps2_data_oe rises at T+1+CLK_HOLD_CYCLES; ps2_clk_oe falls one cycle later.
- Edge response: ps2_data_oe updates 3 cycles after the raw pin falls (2 synchronizer + 1 register). With the filter enabled: 2 + FILTER_LEN + 1 cycles.
- tx_done / tx_err: 1 cycle wide. tx_ready returns to 1 on the cycle after the pulse.
- Counter widths: ceil(log2) of the respective parameter; the hold and timeout counters do not wrap.

## Configuration
- PS2_TX_GLITCH_FILTER_EN defined:
  - The synchronized clock must read low for FILTER_LEN consecutive cycles before a falling edge is declared.
  - The line must read high for FILTER_LEN consecutive cycles before the next edge is re-armed.
  - Low pulses shorter than FILTER_LEN are ignored.
- Not defined: plain single-cycle edge detection; FILTER_LEN is unused.

## Test plan
- Send 0xF4 with a device model clocking at 12.5 kHz and acking → sampled bits 0,0,1,0,1,1,1,1, parity 0, stop 1; ps2_clk_oe low for exactly 6500 cycles; one tx_done pulse; tx_ready back to 1.
- Send 0xFF → 8 data bits of 1, parity 1, then tx_done.
- Device leaves data high at the ack clock → one tx_err pulse, no tx_done, both enables 0.
- Device never clocks after release → tx_err exactly 1300000 cycles after ps2_clk_oe falls; both lines released.
- rst_n asserted mid-SEND after 4 bits → enables 0 in the same cycle with no clk edge needed; tx_ready=1 after release. A following 0xF4 send completes normally. tx_valid pulses while busy are ignored.
- With PS2_TX_GLITCH_FILTER_EN: 3-cycle low glitches on PS2Clk during SEND do not advance bit_cnt and the 0xF4 send still succeeds. Without the macro, the same glitch advances bit_cnt by one.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: request-to-send, 11-bit frame, ack check, timeout.
// Optional macro PS2_TX_GLITCH_FILTER_EN qualifies device clock edges with a FILTER_LEN-sample filter.
`timescale 1ns/1ps
module ps2_host_tx #(
  parameter int unsigned CLK_HOLD_CYCLES = 6500,
  parameter int unsigned TIMEOUT_CYCLES  = 1300000,
  parameter int unsigned FILTER_LEN      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned HoldW = (CLK_HOLD_CYCLES > 1) ? $clog2(CLK_HOLD_CYCLES) : 1;
  localparam int unsigned ToW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(CLK_HOLD_CYCLES - 1);
  localparam logic [ToW-1:0]   ToMax    = ToW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StStart,
    StSend,
    StAck,
    StWaitIdle
  } state_e;

  state_e           state_q, state_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [ToW-1:0]   to_q, to_d;
  logic [3:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;

  logic clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
  logic fall;
  logic timeout_run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      data_s1_q <= 1'b1;
      data_s2_q <= 1'b1;
    end else begin
      clk_s1_q  <= ps2_clk_in;
      clk_s2_q  <= clk_s1_q;
      data_s1_q <= ps2_data_in;
      data_s2_q <= data_s1_q;
    end
  end

`ifdef PS2_TX_GLITCH_FILTER_EN
  localparam int unsigned FiltW = $clog2(FILTER_LEN + 1);
  localparam logic [FiltW-1:0] FiltLast = FiltW'(FILTER_LEN - 1);

  logic [FiltW-1:0] low_cnt_q, high_cnt_q;
  logic             armed_q, fall_q;

  // An edge fires once after FILTER_LEN lows; FILTER_LEN highs are needed to re-arm.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      low_cnt_q  <= '0;
      high_cnt_q <= '0;
      armed_q    <= 1'b1;
      fall_q     <= 1'b0;
    end else begin
      fall_q <= 1'b0;
      if (!clk_s2_q) begin
        high_cnt_q <= '0;
        if (low_cnt_q != FiltLast) low_cnt_q <= low_cnt_q + FiltW'(1);
        if (armed_q && low_cnt_q == FiltLast) begin
          fall_q  <= 1'b1;
          armed_q <= 1'b0;
        end
      end else begin
        low_cnt_q <= '0;
        if (high_cnt_q != FiltLast) high_cnt_q <= high_cnt_q + FiltW'(1);
        if (high_cnt_q == FiltLast) armed_q <= 1'b1;
      end
    end
  end

  assign fall = fall_q;
`else
  logic clk_prev_q;
  logic unused_filter_len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) clk_prev_q <= 1'b1;
    else        clk_prev_q <= clk_s2_q;
  end

  assign fall = clk_prev_q & ~clk_s2_q;
  assign unused_filter_len = ^FILTER_LEN;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      hold_q    <= '0;
      to_q      <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      to_q      <= to_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
    end
  end

  assign timeout_run = (state_q == StSend) || (state_q == StAck) || (state_q == StWaitIdle);

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    to_d      = to_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    tx_done   = 1'b0;
    tx_err    = 1'b0;

    if (timeout_run && to_q != ToMax) to_d = to_q + ToW'(1);

    unique case (state_q)
      StIdle: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx_valid) begin
          shift_d  = tx_data;
          parity_d = ~^tx_data;
          hold_d   = '0;
          clk_oe_d = 1'b1;
          state_d  = StInhibit;
        end
      end
      StInhibit: begin
        if (hold_q == HoldLast) begin
          data_oe_d = 1'b1;
          state_d   = StStart;
        end else begin
          hold_d = hold_q + HoldW'(1);
        end
      end
      StStart: begin
        clk_oe_d = 1'b0;
        to_d     = '0;
        bit_d    = '0;
        state_d  = StSend;
      end
      StSend: begin
        if (fall) begin
          bit_d = bit_q + 4'd1;
          if (bit_q < 4'd8) begin
            data_oe_d = ~shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
          end else if (bit_q == 4'd8) begin
            data_oe_d = ~parity_q;
          end else begin
            data_oe_d = 1'b0;
            state_d   = StAck;
          end
        end
      end
      StAck: begin
        if (fall) begin
          if (!data_s2_q) begin
            state_d = StWaitIdle;
          end else begin
            tx_err    = 1'b1;
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            state_d   = StIdle;
          end
        end
      end
      StWaitIdle: begin
        if (clk_s2_q && data_s2_q) begin
          tx_done = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Timeout wins over any event in the same cycle, so done and err stay exclusive.
    if (timeout_run && to_q == ToMax) begin
      tx_done   = 1'b0;
      tx_err    = 1'b1;
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      state_d   = StIdle;
    end
  end

  assign tx_ready    = (state_q == StIdle);
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: open-drain PS/2 device model, frame and timing reference.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int unsigned HOLD = 40;
  localparam int unsigned TO   = 2000;
  localparam int unsigned FLEN = 8;
  localparam int          HP   = 20;
`ifdef PS2_TX_GLITCH_FILTER_EN
  localparam int LAT = 2 + FLEN + 1;
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_err;
  logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  // Wired-AND bus: either side may pull low.
  assign ps2_clk_in  = ~ps2_clk_oe & ~dev_clk_low;
  assign ps2_data_in = ~ps2_data_oe & ~dev_data_low;

  ps2_host_tx #(
    .CLK_HOLD_CYCLES(HOLD),
    .TIMEOUT_CYCLES (TO),
    .FILTER_LEN     (FLEN)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_done    (tx_done),
    .tx_err     (tx_err),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  logic pulse_d = 1'b0;
  logic ready_in_pulse = 1'b0;
  logic ready_after = 1'b0;
  logic oe_after = 1'b1;
  logic [9:0] smp;

  // Pulse monitor: counts result pulses and records the handshake around them.
  always @(negedge clk) begin
    if (pulse_d) begin
      ready_after = tx_ready;
      oe_after    = ps2_clk_oe | ps2_data_oe;
    end
    pulse_d = tx_done | tx_err;
    if (pulse_d) ready_in_pulse = tx_ready;
    if (tx_done) done_cnt++;
    if (tx_err) err_cnt++;
    if (tx_done && tx_err) both_cnt++;
  end

  // Reference frame as the device sees it on rising edges: 8 data LSB first, odd parity, stop.
  function automatic logic [9:0] frame_of(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, (ones % 2 == 0), b};
  endfunction

  task automatic start_tx(input logic [7:0] b, output logic rdy, output logic coe);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    rdy = tx_ready;
    coe = ps2_clk_oe;
  endtask

  task automatic wait_release();
    int n = 0;
    while (ps2_clk_oe && n < int'(HOLD) + 50) begin
      @(negedge clk);
      n++;
    end
    repeat (30) @(negedge clk);
  endtask

  task automatic dev_clock(input int from, input int to);
    for (int i = from; i <= to; i++) begin
      dev_clk_low = 1'b1;
      repeat (HP) @(negedge clk);
      dev_clk_low = 1'b0;
      smp[i] = ps2_data_in;
      repeat (HP) @(negedge clk);
    end
  endtask

  task automatic dev_ack(input logic ack_low);
    dev_data_low = ack_low;
    repeat (4) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (HP) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (3) @(negedge clk);
    dev_data_low = 1'b0;
  endtask

  task automatic wait_result(input int d0, input int e0);
    int n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b);
    logic rdy, coe;
    start_tx(b, rdy, coe);
    wait_release();
    dev_clock(0, 9);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", tx_ready); end
    total++; if (ps2_clk_oe !== 1'b0) begin bad++; $display("FAIL reset_clk_oe: got %b want 0", ps2_clk_oe); end
    total++; if (ps2_data_oe !== 1'b0) begin bad++; $display("FAIL reset_data_oe: got %b want 0", ps2_data_oe); end
    total++; if ({tx_done, tx_err} !== 2'b00) begin bad++; $display("FAIL reset_pulses: got %b want 00", {tx_done, tx_err}); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL idle_ready: got %b want 1", tx_ready); end
  endtask

  task automatic test_send(input logic [7:0] b);
    logic rdy, coe;
    logic [9:0] f = frame_of(b);
    int d0 = done_cnt;
    int e0 = err_cnt;
    start_tx(b, rdy, coe);
    total++; if ({rdy, coe} !== 2'b01) begin bad++; $display("FAIL accept_%h: ready,clk_oe=%b want 01", b, {rdy, coe}); end
    // A new request while busy must not be taken.
    tx_data  = ~b;
    tx_valid = 1'b1;
    repeat (HOLD - 1) @(negedge clk);
    tx_valid = 1'b0;
    total++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b10) begin bad++; $display("FAIL hold_end_%h: clk,data oe=%b want 10", b, {ps2_clk_oe, ps2_data_oe}); end
    @(negedge clk);
    total++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b11) begin bad++; $display("FAIL start_%h: clk,data oe=%b want 11", b, {ps2_clk_oe, ps2_data_oe}); end
    @(negedge clk);
    total++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b01) begin bad++; $display("FAIL release_%h: clk,data oe=%b want 01", b, {ps2_clk_oe, ps2_data_oe}); end
    repeat (30) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (LAT - 1) @(negedge clk);
    total++; if (ps2_data_oe !== 1'b1) begin bad++; $display("FAIL early_%h: data_oe=%b want 1", b, ps2_data_oe); end
    @(negedge clk);
    total++; if (ps2_data_oe !== ~f[0]) begin bad++; $display("FAIL latency_%h: data_oe=%b want %b", b, ps2_data_oe, ~f[0]); end
    repeat (HP - LAT) @(negedge clk);
    dev_clk_low = 1'b0;
    smp[0] = ps2_data_in;
    repeat (HP) @(negedge clk);
    dev_clock(1, 9);
    total++; if (smp !== f) begin bad++; $display("FAIL frame_%h: got %b want %b", b, smp, f); end
    dev_ack(1'b1);
    wait_result(d0, e0);
    total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL done_%h: pulses %0d want 1", b, done_cnt - d0); end
    total++; if (err_cnt - e0 !== 0) begin bad++; $display("FAIL noerr_%h: pulses %0d want 0", b, err_cnt - e0); end
    total++; if ({ready_in_pulse, ready_after} !== 2'b01) begin bad++; $display("FAIL ready_%h: during,after=%b want 01", b, {ready_in_pulse, ready_after}); end
    total++; if (oe_after !== 1'b0) begin bad++; $display("FAIL lines_%h: oe=%b want 0", b, oe_after); end
  endtask

  task automatic test_nack();
    logic [7:0] b = 8'($urandom);
    int d0 = done_cnt;
    int e0 = err_cnt;
    send_frame(b);
    dev_ack(1'b0);
    wait_result(d0, e0);
    total++; if (err_cnt - e0 !== 1) begin bad++; $display("FAIL nack_err: pulses %0d want 1", err_cnt - e0); end
    total++; if (done_cnt - d0 !== 0) begin bad++; $display("FAIL nack_done: pulses %0d want 0", done_cnt - d0); end
    total++; if ({ready_after, oe_after} !== 2'b10) begin bad++; $display("FAIL nack_idle: ready,oe=%b want 10", {ready_after, oe_after}); end
  endtask

  task automatic test_timeout();
    logic rdy, coe;
    int n = 0;
    int m = 0;
    int e0 = err_cnt;
    start_tx(8'($urandom), rdy, coe);
    while (ps2_clk_oe && m < int'(HOLD) + 50) begin
      @(negedge clk);
      m++;
    end
    while (!tx_err && n < 2 * int'(TO)) begin
      @(negedge clk);
      n++;
    end
    total++; if (n !== int'(TO)) begin bad++; $display("FAIL timeout_cycles: got %0d want %0d", n, TO); end
    @(negedge clk);
    total++; if ({ps2_clk_oe, ps2_data_oe, tx_ready} !== 3'b001) begin bad++; $display("FAIL timeout_idle: clk_oe,data_oe,ready=%b want 001", {ps2_clk_oe, ps2_data_oe, tx_ready}); end
    total++; if (err_cnt - e0 !== 1) begin bad++; $display("FAIL timeout_err: pulses %0d want 1", err_cnt - e0); end
  endtask

  task automatic test_reset_mid_send();
    logic rdy, coe;
    start_tx(8'hF4, rdy, coe);
    repeat (5) @(negedge clk);
    total++; if (ps2_clk_oe !== 1'b1) begin bad++; $display("FAIL inhibit_clk_oe: got %b want 1", ps2_clk_oe); end
    #1 rst_n = 1'b0;
    #1;
    total++; if (ps2_clk_oe !== 1'b0) begin bad++; $display("FAIL async_rst_inhibit: clk_oe=%b want 0", ps2_clk_oe); end
    @(negedge clk);
    rst_n = 1'b1;
    start_tx(8'hF4, rdy, coe);
    wait_release();
    dev_clock(0, 3);
    total++; if (ps2_data_oe !== 1'b1) begin bad++; $display("FAIL bit3_drive: data_oe=%b want 1", ps2_data_oe); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin bad++; $display("FAIL async_rst_send: oe=%b want 00", {ps2_clk_oe, ps2_data_oe}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", tx_ready); end
  endtask

  task automatic test_glitch();
    logic [9:0] f = frame_of(8'hF4);
    int d0 = done_cnt;
    int e0 = err_cnt;
    logic rdy, coe;
    start_tx(8'hF4, rdy, coe);
    wait_release();
    dev_clock(0, 1);
    repeat (3) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (3) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (15) @(negedge clk);
`ifdef PS2_TX_GLITCH_FILTER_EN
    total++; if (ps2_data_oe !== ~f[1]) begin bad++; $display("FAIL glitch_hold: data_oe=%b want %b", ps2_data_oe, ~f[1]); end
    dev_clock(2, 9);
    total++; if (smp !== f) begin bad++; $display("FAIL glitch_frame: got %b want %b", smp, f); end
    dev_ack(1'b1);
    wait_result(d0, e0);
    total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL glitch_done: pulses %0d want 1", done_cnt - d0); end
`else
    total++; if (ps2_data_oe !== ~f[2]) begin bad++; $display("FAIL glitch_advance: data_oe=%b want %b", ps2_data_oe, ~f[2]); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if ({tx_ready, done_cnt - d0 == 0, err_cnt - e0 == 0} !== 3'b111) begin bad++; $display("FAIL glitch_abort: ready,nodone,noerr=%b want 111", {tx_ready, done_cnt - d0 == 0, err_cnt - e0 == 0}); end
`endif
  endtask

  initial begin
    test_reset();
    test_send(8'hF4);
    test_send(8'hFF);
    repeat (3) test_send(8'($urandom));
    test_nack();
    test_timeout();
    test_reset_mid_send();
    test_send(8'hF4);
    test_glitch();
    total++; if (both_cnt !== 0) begin bad++; $display("FAIL exclusive_pulses: overlaps %0d want 0", both_cnt); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
